// File: rtl/dice_pkg.sv
// Definitions shared by the electronic dice and its downstream tracker:
// throw encoding, legal face range and the tracker FSM state set.
package dice_pkg;

    localparam int THROW_W = 3;

    typedef logic [THROW_W-1:0] throw_t;

    localparam throw_t THROW_MIN = 3'd1;
    localparam throw_t THROW_MAX = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROLLING,
        ST_SETTLE,
        ST_PRESENT
    } tracker_state_t;

    function automatic logic is_valid_throw(input throw_t t);
        return (t >= THROW_MIN) && (t <= THROW_MAX);
    endfunction

endpackage

// File: rtl/dice_roll_tracker_sat_add.sv
// Unsigned adder that clamps to all-ones instead of wrapping.
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    logic [W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/dice_roll_tracker.sv
// Captures the settled dice value after button release, presents it on a
// valid/ready handshake and keeps saturating roll-count and score totals.
module dice_roll_tracker
    import dice_pkg::*;
#(
    parameter int COUNT_W = 8,
    parameter int SUM_W   = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [THROW_W-1:0] throw,
    output logic [THROW_W-1:0] result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               repeat_flag,
    output logic [COUNT_W-1:0] roll_count,
    output logic [SUM_W-1:0]   total,
    output logic               bad_throw
);

    tracker_state_t     r_state;
    tracker_state_t     w_next;
    logic [THROW_W-1:0] r_result;
    logic [THROW_W-1:0] r_last;
    logic               r_have_prev;
    logic               r_valid;
    logic               r_repeat;
    logic               r_bad;
    logic [COUNT_W-1:0] r_count;
    logic [SUM_W-1:0]   r_total;
    logic [COUNT_W-1:0] w_count_inc;
    logic [SUM_W-1:0]   w_total_inc;
    logic               w_throw_ok;
    logic               w_accept;

    assign w_throw_ok = is_valid_throw(throw);
    assign w_accept   = (r_state == ST_PRESENT) && result_ready;

    sat_add #(.W(COUNT_W)) u_count_add (
        .i_a   (r_count),
        .i_b   (COUNT_W'(1)),
        .o_sum (w_count_inc)
    );

    sat_add #(.W(SUM_W)) u_total_add (
        .i_a   (r_total),
        .i_b   (SUM_W'(r_result)),
        .o_sum (w_total_inc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (button)       w_next = ST_ROLLING;
            ST_ROLLING: if (!button)      w_next = ST_SETTLE;
            ST_SETTLE:  w_next = w_throw_ok ? ST_PRESENT : ST_IDLE;
            ST_PRESENT: if (result_ready) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_result    <= '0;
            r_last      <= '0;
            r_have_prev <= 1'b0;
            r_valid     <= 1'b0;
            r_repeat    <= 1'b0;
            r_bad       <= 1'b0;
            r_count     <= '0;
            r_total     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_SETTLE) begin
                if (w_throw_ok) begin
                    r_result <= throw;
                    r_valid  <= 1'b1;
                    r_repeat <= r_have_prev && (throw == r_last);
                end else begin
                    r_bad <= 1'b1;
                end
            end
            // Result register keeps the accepted value; only valid/repeat drop.
            if (w_accept) begin
                r_valid     <= 1'b0;
                r_repeat    <= 1'b0;
                r_last      <= r_result;
                r_have_prev <= 1'b1;
                r_count     <= w_count_inc;
                r_total     <= w_total_inc;
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign repeat_flag  = r_repeat;
    assign roll_count   = r_count;
    assign total        = r_total;
    assign bad_throw    = r_bad;

endmodule
